chunk_serial_adder: RTL and testbench

CHUNK_SERIAL_ADDER -- requirements
Module: chunk_serial_adder

---
 rtl/chunk_serial_adder.sv | 138 +++++++++++++
 tb/tb_chunk_serial_adder.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder/subtractor that processes CHUNK bits per clock, LSB chunk first.
// It takes one capture cycle plus N = WIDTH/CHUNK add cycles, then pulses done for one cycle.

module chunk_serial_adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o
);
  logic [CHUNK:0] full;

  assign full = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
  assign s_o  = full[CHUNK-1:0];
  assign c_o  = full[CHUNK];
endmodule

module chunk_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             done_q;

  logic [CHUNK-1:0] ch_sum;
  logic             ch_co;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] acc_d;
  logic             last;

  // Operands shift right so the active chunk always sits in the low bits;
  // finished chunks enter the accumulator from the top.
  chunk_serial_adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i (a_q[CHUNK-1:0]),
    .b_i (b_q[CHUNK-1:0]),
    .c_i (carry_q),
    .s_o (ch_sum),
    .c_o (ch_co)
  );

  generate
    if (N > 1) begin : g_multi
      assign a_d   = {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
      assign b_d   = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
      assign acc_d = {ch_sum, acc_q[WIDTH-1:CHUNK]};
    end else begin : g_single
      assign a_d   = '0;
      assign b_d   = '0;
      assign acc_d = ch_sum;
    end
  endgenerate

  assign last = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? ~cin : cin;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_d;
          b_q     <= b_d;
          acc_q   <= acc_d;
          carry_q <= ch_co;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            sum_q   <= acc_d;
            cout_q  <= ch_co;
            ovf_q   <= (a_msb_q == b_msb_q) && (acc_d[WIDTH-1] != a_msb_q);
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_chunk_serial_adder.sv
// Directed bench for chunk_serial_adder: a 4-bit-chunk instance and a single-chunk instance.
module tb_chunk_serial_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  logic        start1 = 1'b0;
  logic [15:0] a1 = '0, b1 = '0;
  logic        busy1, done1, cout1, ovf1;
  logic [15:0] sum1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  chunk_serial_adder #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(1'b0), .sub(1'b0),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; sample and drive 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts);
    a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
  endtask

  initial begin
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick();

    // 5 + 1
    go(16'h0005, 16'h0001, 1'b0, 1'b0);
    tick();                                 // E0
    start = 1'b0;
    chk("t1_busy_e0", busy, 1);
    tick(); chk("t1_busy_e1", busy, 1);
    tick(); chk("t1_busy_e2", busy, 1);
    tick(); chk("t1_busy_e3", busy, 1); chk("t1_nodone_e3", done, 0); chk("t1_sum_hold", sum, 0);
    tick();                                 // E4
    chk("t1_done", done, 1); chk("t1_busy_e4", busy, 0);
    chk("t1_sum", sum, 16'h0006); chk("t1_cout", cout, 0); chk("t1_ovf", ovf, 0);
    tick(); chk("t1_done_low", done, 0); chk("t1_sum_stable", sum, 16'h0006);

    // FFFF + 1: carry ripples across every chunk
    go(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    tick(); start = 1'b0;
    repeat (4) tick();
    chk("t2_done", done, 1); chk("t2_sum", sum, 16'h0000); chk("t2_cout", cout, 1); chk("t2_ovf", ovf, 0);

    // 7FFF + 1 overflows positive to negative
    go(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    tick(); start = 1'b0;
    repeat (4) tick();
    chk("t3_done", done, 1); chk("t3_sum", sum, 16'h8000); chk("t3_cout", cout, 0); chk("t3_ovf", ovf, 1);

    // 5 - 7 = FFFE, borrow so raw carry is 0
    go(16'h0005, 16'h0007, 1'b0, 1'b1);
    tick(); start = 1'b0;
    repeat (4) tick();
    chk("t4_done", done, 1); chk("t4_sum", sum, 16'hFFFE); chk("t4_cout", cout, 0); chk("t4_ovf", ovf, 0);

    // Start while busy is ignored; start in the done cycle is accepted
    go(16'h0005, 16'h0001, 1'b0, 1'b0);
    tick(); start = 1'b0;                   // E0
    tick();                                 // E1
    go(16'h1111, 16'h2222, 1'b1, 1'b1);
    tick(); start = 1'b0;                   // E2, must be ignored
    tick();                                 // E3
    tick();                                 // E4
    chk("t5_done", done, 1); chk("t5_sum", sum, 16'h0006); chk("t5_ovf", ovf, 0);
    go(16'h0002, 16'h0003, 1'b0, 1'b0);     // held during done cycle
    tick();
    start = 1'b0;
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b1;
    chk("t5_b2b_busy", busy, 1); chk("t5_b2b_nodone", done, 0); chk("t5_b2b_sum_hold", sum, 16'h0006);
    tick(); tick(); tick();
    chk("t5_b2b_e3", done, 0); chk("t5_b2b_sum_hold2", sum, 16'h0006);
    tick();
    chk("t5_b2b_done", done, 1); chk("t5_b2b_sum", sum, 16'h0005); chk("t5_b2b_cout", cout, 0);

    // Reset mid-run aborts with no done pulse
    go(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    tick(); start = 1'b0;
    tick(); tick();                         // E1, E2
    rst = 1'b1;
    #1;
    chk("t6_busy", busy, 0); chk("t6_sum", sum, 0); chk("t6_cout", cout, 0);
    chk("t6_ovf", ovf, 0); chk("t6_done", done, 0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    chk("t6_nodone", done, 0); chk("t6_idle", busy, 0);
    go(16'h1234, 16'h1111, 1'b1, 1'b0);
    tick(); start = 1'b0;
    repeat (3) tick();
    chk("t6_e3_nodone", done, 0);
    tick();
    chk("t6_done2", done, 1); chk("t6_sum2", sum, 16'h2346); chk("t6_cout2", cout, 0);

    // Single-chunk instance
    a1 = 16'h8000; b1 = 16'h8000; start1 = 1'b1;
    tick(); start1 = 1'b0;
    chk("t7_busy", busy1, 1); chk("t7_nodone", done1, 0);
    tick();
    chk("t7_done", done1, 1); chk("t7_busy_low", busy1, 0);
    chk("t7_sum", sum1, 16'h0000); chk("t7_cout", cout1, 1); chk("t7_ovf", ovf1, 1);
    tick();
    chk("t7_done_low", done1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
